// File: rtl/lif_pkg.sv
// Shared constants, types and helpers for the leaky integrate-and-fire layer.
package lif_pkg;

   localparam int unsigned BETA_W   = 8;
   localparam int unsigned REFRAC_W = 4;
   // Widest supported WIDTH; the saturating adder is sized for it.
   localparam int unsigned SAT_W    = 16;

   typedef enum logic [0:0] {
      RESET_ZERO = 1'b0,
      RESET_SUB  = 1'b1
   } reset_mode_e;

   // Unsigned add clamped to 2^width-1 (width <= SAT_W).
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned width);
      logic [SAT_W:0] s;
      logic [SAT_W:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
      return (s > lim) ? lim[SAT_W-1:0] : s[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane register, spike flag and,
// when LIF_REFRACTORY_EN is defined, a refractory counter.
module lif_cell
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned RESET_MODE   = 0,
   parameter int unsigned REFRAC_STEPS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic [WIDTH-1:0]  current,
   input  logic [BETA_W-1:0] beta,
   input  logic [WIDTH-1:0]  threshold,
   output logic [WIDTH-1:0]  state,
   output logic              spike
);

   localparam reset_mode_e Mode = (RESET_MODE == 1) ? RESET_SUB : RESET_ZERO;
   localparam int unsigned ProdW = WIDTH + BETA_W;

   logic [WIDTH-1:0] v_q, v_d;
   logic             spike_q, spike_d;
   logic [ProdW-1:0] prod;
   logic [WIDTH-1:0] leak;
   logic [WIDTH-1:0] sum;
   logic             fire;
   logic [WIDTH-1:0] v_fire;
   logic             unused_bits;

   assign prod = ProdW'(v_q) * ProdW'(beta);
   assign leak = prod[ProdW-1:BETA_W];
   assign sum  = WIDTH'(sat_add(SAT_W'(leak), SAT_W'(current), WIDTH));
   assign fire = (sum >= threshold);

   always_comb begin
      v_fire = '0;
      if (Mode == RESET_SUB) begin
         v_fire = sum - threshold;
      end
   end

`ifdef LIF_REFRACTORY_EN
   logic [REFRAC_W-1:0] cnt_q, cnt_d;

   always_comb begin
      v_d     = v_q;
      spike_d = spike_q;
      cnt_d   = cnt_q;
      if (step) begin
         if (cnt_q != '0) begin
            // Refractory: v frozen at its post-spike value, no spike.
            cnt_d   = cnt_q - REFRAC_W'(1);
            spike_d = 1'b0;
         end else if (fire) begin
            cnt_d   = REFRAC_W'(REFRAC_STEPS);
            spike_d = 1'b1;
            v_d     = v_fire;
         end else begin
            spike_d = 1'b0;
            v_d     = sum;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign unused_bits = ^prod[BETA_W-1:0];
`else
   always_comb begin
      v_d     = v_q;
      spike_d = spike_q;
      if (step) begin
         spike_d = fire;
         v_d     = fire ? v_fire : sum;
      end
   end

   assign unused_bits = ^{prod[BETA_W-1:0], REFRAC_W'(REFRAC_STEPS)};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q     <= '0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         spike_q <= spike_d;
      end
   end

   assign state = v_q;
   assign spike = spike_q;

endmodule

// File: rtl/lif_layer.sv
// Layer of N_NEURONS independent LIF neurons sharing beta and threshold.
// Optional refractory behaviour is enabled by defining LIF_REFRACTORY_EN.
module lif_layer
   import lif_pkg::*;
#(
   parameter int unsigned N_NEURONS    = 4,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned RESET_MODE   = 0,
   parameter int unsigned REFRAC_STEPS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       step,
   input  logic [N_NEURONS*WIDTH-1:0] current,
   input  logic [BETA_W-1:0]          beta,
   input  logic [WIDTH-1:0]           threshold,
   output logic [N_NEURONS-1:0]       spike,
   output logic [N_NEURONS*WIDTH-1:0] state,
   output logic                       out_valid
);

   logic out_valid_q;

   for (genvar i = 0; i < N_NEURONS; i++) begin : g_cell
      lif_cell #(
         .WIDTH        (WIDTH),
         .RESET_MODE   (RESET_MODE),
         .REFRAC_STEPS (REFRAC_STEPS)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .step      (step),
         .current   (current[i*WIDTH +: WIDTH]),
         .beta      (beta),
         .threshold (threshold),
         .state     (state[i*WIDTH +: WIDTH]),
         .spike     (spike[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= step;
      end
   end

   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lif_layer.sv
// Self-checking bench: two layers (reset-to-zero and reset-by-subtraction)
// driven in parallel and compared against an arithmetic reference model.
module tb_lif_layer;

   localparam int N = 4;
   localparam int W = 8;
   localparam int REFRAC = 2;
   localparam int VMAX = (1 << W) - 1;
`ifdef LIF_REFRACTORY_EN
   localparam bit REFRAC_ON = 1'b1;
`else
   localparam bit REFRAC_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           step;
   logic [N*W-1:0] current;
   logic [7:0]     beta;
   logic [W-1:0]   threshold;
   logic [N-1:0]   spike_z, spike_s;
   logic [N*W-1:0] state_z, state_s;
   logic           valid_z, valid_s;

   int checks = 0;
   int errors = 0;

   // Model state, index 0 = reset-to-zero layer, 1 = subtractive layer.
   int mv  [2][N];
   int mrc [2][N];
   bit msp [2][N];
   bit mvalid;

   always #5 clk = ~clk;

   lif_layer #(.N_NEURONS(N), .WIDTH(W), .RESET_MODE(0), .REFRAC_STEPS(REFRAC)) dut_z (
      .clk(clk), .rst(rst), .step(step), .current(current), .beta(beta),
      .threshold(threshold), .spike(spike_z), .state(state_z), .out_valid(valid_z)
   );

   lif_layer #(.N_NEURONS(N), .WIDTH(W), .RESET_MODE(1), .REFRAC_STEPS(REFRAC)) dut_s (
      .clk(clk), .rst(rst), .step(step), .current(current), .beta(beta),
      .threshold(threshold), .spike(spike_s), .state(state_s), .out_valid(valid_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            mv[m][i] = 0; mrc[m][i] = 0; msp[m][i] = 1'b0;
         end
      end
      mvalid = 1'b0;
   endfunction

   function automatic void model_step();
      int c, lk, sum;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            c = int'(current[i*W +: W]);
            if (REFRAC_ON && mrc[m][i] > 0) begin
               mrc[m][i]--;
               msp[m][i] = 1'b0;
            end else begin
               lk  = (mv[m][i] * int'(beta)) / 256;
               sum = lk + c;
               if (sum > VMAX) sum = VMAX;
               if (sum >= int'(threshold)) begin
                  msp[m][i] = 1'b1;
                  mv[m][i]  = (m == 1) ? sum - int'(threshold) : 0;
                  mrc[m][i] = REFRAC;
               end else begin
                  msp[m][i] = 1'b0;
                  mv[m][i]  = sum;
               end
            end
         end
      end
   endfunction

   task automatic check_all(input string tag);
      logic [N-1:0]   es [2];
      logic [N*W-1:0] ev [2];
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) begin
            es[m][i] = msp[m][i];
            ev[m][i*W +: W] = W'(mv[m][i]);
         end
      end
      check({tag, "_spike_z"}, 32'(spike_z), 32'(es[0]));
      check({tag, "_state_z"}, 32'(state_z), 32'(ev[0]));
      check({tag, "_valid_z"}, 32'(valid_z), 32'(mvalid));
      check({tag, "_spike_s"}, 32'(spike_s), 32'(es[1]));
      check({tag, "_state_s"}, 32'(state_s), 32'(ev[1]));
      check({tag, "_valid_s"}, 32'(valid_s), 32'(mvalid));
   endtask

   // Inputs are set by the caller away from the edge; outputs sampled 1 after it.
   task automatic cycle(input bit st, input string tag);
      step = st;
      @(posedge clk);
      if (!rst) begin
         if (st) model_step();
         mvalid = st;
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; step = 1'b0; current = '0; beta = 8'd255; threshold = 8'd150;
      model_reset();
      #2;
      check_all("por");
      do_reset();

      // Leak-free integration, both reset modes.
      beta = 8'd255; threshold = 8'd150; current = 32'd100;
      cycle(1'b1, "int1");
      check("int1_state0", 32'(state_z[7:0]), 32'd100);
      cycle(1'b1, "int2");
      check("int2_spike0_z", 32'(spike_z[0]), 32'd1);
      check("int2_state0_z", 32'(state_z[7:0]), 32'd0);
      check("int2_state0_s", 32'(state_s[7:0]), 32'd49);
      current = '0;
      cycle(1'b1, "int3");
      check("int3_state0_s", 32'(state_s[7:0]), 32'd48);
      check("int3_spike0_s", 32'(spike_s[0]), 32'd0);

      // Leak and idle hold; inputs wiggle between steps without effect.
      do_reset();
      threshold = 8'd255; beta = 8'd255; current = 32'd200;
      cycle(1'b1, "leak_load");
      beta = 8'd128; current = '0;
      cycle(1'b1, "leak");
      check("leak_state0", 32'(state_z[7:0]), 32'd100);
      for (int k = 0; k < 5; k++) begin
         current = $urandom; beta = 8'($urandom); threshold = 8'($urandom);
         cycle(1'b0, "idle");
      end
      check("idle_state0", 32'(state_s[7:0]), 32'd100);

      // Saturation and channel independence.
      do_reset();
      threshold = 8'd255; beta = 8'd255; current = {8'd10, 8'd0, 8'd255, 8'd255};
      cycle(1'b1, "sat");
      check("sat_spike_s", 32'(spike_s), 32'b0011);
      check("sat_state_s", 32'(state_s), {8'd10, 8'd0, 8'd0, 8'd0});

      // Refractory pattern (or continuous firing without the feature).
      do_reset();
      threshold = 8'd150; beta = 8'd255; current = 32'd200;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, "refrac");
         check("refrac_spike0", 32'(spike_z[0]),
               32'((!REFRAC_ON || (k % 3 == 0)) ? 1 : 0));
      end

      // Randomized stimulus against the model.
      do_reset();
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) begin
            current[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'($urandom) :
                                8'($urandom_range(0, 60));
         end
         beta = 8'($urandom);
         threshold = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(40, 255));
         cycle($urandom_range(0, 3) != 0, "rand");
      end

      // Reset mid-run between back-to-back steps.
      threshold = 8'd200; beta = 8'd200; current = {8'd30, 8'd20, 8'd90, 8'd60};
      cycle(1'b1, "pre_rst1");
      cycle(1'b1, "pre_rst2");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("rst_async");
      cycle(1'b1, "rst_held");
      #2;
      rst = 1'b0;
      threshold = 8'd150; beta = 8'd255; current = 32'd100;
      cycle(1'b1, "post_rst");
      check("post_rst_state0", 32'(state_z[7:0]), 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lif_layer.md
# lif_layer

Parametrised layer of leaky integrate-and-fire neurons sharing one clock, one leak factor and one firing threshold. Each neuron integrates its own input current once per time step, leaks its membrane potential multiplicatively, fires a one-step spike when the potential crosses threshold, and then resets. The layer is the next-generation neuron core under the top-level wrapper: it replaces the single fixed-width neuron, and a wrapper maps switch/IO pins onto its channels.

## Interface
- `N_NEURONS`, 4: number of independent neuron channels (1..16).
- `WIDTH`, 8: membrane potential, current and threshold width in bits (4..16).
- `RESET_MODE`, 0: 0 = reset-to-zero on spike; 1 = reset-by-subtraction of threshold.
- `REFRAC_STEPS`, 2: refractory length in time steps (1..15). Only used with `LIF_REFRACTORY_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `step`  in  1  time-step strobe; one integration per cycle with `step`=1.
- `current`  in  N_NEURONS*WIDTH  unsigned input current; neuron i uses bits [i*WIDTH +: WIDTH].
- `beta`  in  8  leak factor; leaked = (v*beta)>>8; 255 = slowest leak.
- `threshold`  in  WIDTH  firing threshold, unsigned.
- `spike`  out  N_NEURONS  registered spike flags of the last step.
- `state`  out  N_NEURONS*WIDTH  registered membrane potentials, same packing as `current`.
- `out_valid`  out  1  one-cycle pulse: `spike`/`state` updated from a step.

## Operation
- Per neuron, on a cycle with `step`=1:
  - `leak = (v * beta) >> 8`, full-precision product (WIDTH+8 bits), truncated.
  - `sum = leak + current_i`, computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - fire = (sum >= threshold); threshold 0 fires every non-refractory step.
  - On fire: `spike_i`=1; v ← 0 if RESET_MODE=0, v ← sum-threshold if RESET_MODE=1.
  - Otherwise: `spike_i`=0, v ← sum.
- Cycles with `step`=0: v, `spike` hold; `out_valid`=0.
- `beta`, `threshold` and `current` are sampled only on step cycles; changes between steps have no effect.
- Neurons are fully independent; no lateral connections inside the layer.
- Reset (any time, including mid-step): all v=0, `spike`=0, `out_valid`=0, refractory counters=0, asynchronously. First step after deassertion integrates from 0.

## Timing
- Latency 1: the step in cycle t drives `state`, `spike` and `out_valid`=1 in cycle t+1.
- Back-to-back steps are legal every cycle, with throughput 1 step/cycle. `out_valid` then stays high continuously.
- `spike` remains asserted until the next step recomputes it, so it is a level per step, not a pulse per cycle.
- Combinational path: one multiply, one add and one compare per neuron, all within a single cycle. No pipelining.

## Configuration
- `LIF_REFRACTORY_EN` defined:
  - Each neuron has a 4-bit refractory counter, loaded with REFRAC_STEPS on fire.
  - While the counter is nonzero, a step decrements it, holds v at its post-spike value, ignores current and leak, and forces `spike_i`=0.
  - A step with the counter at 0 integrates normally.
- Not defined: no counters are present, and a neuron can fire on consecutive steps.

## Structure
- Package `lif_pkg`:
  - `BETA_W`=8 constant.
  - `reset_mode_e` enum (`RESET_ZERO`, `RESET_SUB`).
  - Saturating-add function.
  - Refractory counter width constant (4).
- Sub-module `lif_cell`: one neuron holding its v register, spike register and optional refractory counter. `lif_layer` instantiates N_NEURONS copies with a generate loop. `out_valid` is generated once in `lif_layer`.

## Test plan
All cases use N_NEURONS=4 and WIDTH=8 unless noted.
- Leak-free integration: beta=255, threshold=150, current0=100, RESET_MODE=0, two steps → states 100 then 199 internally; second step outputs spike0=1, state0=0.
- Subtractive reset: as above with RESET_MODE=1 → after step 2, spike0=1, state0=49; step 3 with current 0 → state0=48, spike0=0.
- Leak and idle hold: beta=128, threshold=255, v=200, current 0 → state 100. With `step`=0 for 5 cycles → state stays 100 and `out_valid`=0.
- Saturation and channel independence: currents {255,255,0,10}, threshold=255, beta=255, RESET_MODE=1 → step 1: spike=4'b0011, state={0,0,0,10}; neurons 2/3 are unaffected by 0/1.
- Refractory (`LIF_REFRACTORY_EN`, REFRAC_STEPS=2): threshold=150, current0=200 every step → spike0 pattern 1,0,0,1,0,0; state0=0 during refractory. Without the macro → spike0 is 1 on every step.
- Reset mid-run: assert `rst` between two back-to-back steps → outputs clear immediately, with no `out_valid` pulse. The first step after release with current0=100 yields state0=100.
